mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_wait_timer.sv | 33 +++
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state
// encoding and the default watchdog limit.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for the WAIT state: an 8-bit counter that restarts when a new
// access is accepted and flags expiry on the last allowed WAIT cycle.
// Only instantiated when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [7:0] count;

  // Count WAIT cycles; restart whenever a fresh access enters WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  // The count starts at zero in the first WAIT cycle, so MAX_WAIT cycles have
  // elapsed when the count reaches MAX_WAIT-1.
  assign expired = count_en && (count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage. Holds the pipeline in
// stall while a load/store is outstanding, registers the memory request and
// captures load data. Optional watchdog enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] st_val,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        timeout
);

  mem_state_t state, next_state;
  logic       access;
  logic       wait_expired;

  assign access = mem_r_en | mem_w_en;

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == IDLE) && access),
    .count_en (state == WAIT),
    .expired  (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stall: stall covers the detect cycle and all of WAIT,
  // then DONE releases the pipeline for exactly one advance.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ready || wait_expired) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request registers and load capture; a write wins when both enables are
  // set, and dmem_we==0 during WAIT identifies the access as a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_wdata  <= 32'd0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_w_en;
            dmem_addr  <= alu_res;
            dmem_wdata <= st_val;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!dmem_we) begin
              rdata       <= dmem_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (wait_expired) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            timeout  <= 1'b1;
            if (!dmem_we) begin
              rdata       <= 32'd0;
              rdata_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
